// File: rtl/r4u1_rom_pkg.sv
// Shared constants for the radix-4 unit-1 twiddle ROM: geometry, Q1.14 base table
// and the elaboration-time rescale to other coefficient widths.
package r4u1_rom_pkg;

   localparam int R4U1_ROM_DEPTH = 8;
   localparam int R4U1_ADDR_W    = 3;
   localparam int R4U1_BASE_FRAC = 14;

   // W_16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), k = 0..7, in Q1.14
   localparam int R4U1_BASE_RE [R4U1_ROM_DEPTH] =
      '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
   localparam int R4U1_BASE_IM [R4U1_ROM_DEPTH] =
      '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};

   // Scale a Q1.14 value to 'frac' fractional bits, rounding half away from zero.
   function automatic int r4u1_rescale(input int base, input int frac);
      int sh;
      int mag;
      int res;
      if (frac >= R4U1_BASE_FRAC) begin
         res = base <<< (frac - R4U1_BASE_FRAC);
      end else begin
         sh  = R4U1_BASE_FRAC - frac;
         mag = (base < 0) ? -base : base;
         mag = (mag + (1 <<< (sh - 1))) >>> sh;
         res = (base < 0) ? -mag : mag;
      end
      return res;
   endfunction

endpackage

// File: rtl/r4u1_twiddle_lut.sv
// Combinational twiddle table: addr -> {re, im} at COEF_WIDTH bits, all entries
// fixed at elaboration; zero latency, no backpressure.
module r4u1_twiddle_lut
   import r4u1_rom_pkg::*;
#(
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = COEF_WIDTH - 2
) (
   input  logic [R4U1_ADDR_W-1:0]  addr,
   output logic [2*COEF_WIDTH-1:0] coef
);

   function automatic logic [2*COEF_WIDTH-1:0] entry(input int k);
      int re;
      int im;
      re = r4u1_rescale(R4U1_BASE_RE[k], COEF_FRAC);
      im = r4u1_rescale(R4U1_BASE_IM[k], COEF_FRAC);
      return {re[COEF_WIDTH-1:0], im[COEF_WIDTH-1:0]};
   endfunction

   localparam logic [2*COEF_WIDTH-1:0] E0 = entry(0);
   localparam logic [2*COEF_WIDTH-1:0] E1 = entry(1);
   localparam logic [2*COEF_WIDTH-1:0] E2 = entry(2);
   localparam logic [2*COEF_WIDTH-1:0] E3 = entry(3);
   localparam logic [2*COEF_WIDTH-1:0] E4 = entry(4);
   localparam logic [2*COEF_WIDTH-1:0] E5 = entry(5);
   localparam logic [2*COEF_WIDTH-1:0] E6 = entry(6);
   localparam logic [2*COEF_WIDTH-1:0] E7 = entry(7);

   always_comb begin
      coef = '0;
      case (addr)
         3'd0: coef = E0;
         3'd1: coef = E1;
         3'd2: coef = E2;
         3'd3: coef = E3;
         3'd4: coef = E4;
         3'd5: coef = E5;
         3'd6: coef = E6;
         3'd7: coef = E7;
      endcase
   end

endmodule

// File: rtl/r4u1_twiddle_rom.sv
// Registered twiddle ROM for radix-4 unit 1; latency 1 (2 with R4U1_ROM_OUT_REG_EN),
// no backpressure: every rd_en cycle is a lookup, data holds while rd_en is low.
module r4u1_twiddle_rom
   import r4u1_rom_pkg::*;
#(
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = COEF_WIDTH - 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rd_en,
   input  logic [R4U1_ADDR_W-1:0]  rom_addr,
   output logic [2*COEF_WIDTH-1:0] rom_data,
   output logic                    rom_valid
);

   logic [2*COEF_WIDTH-1:0] lut_dat;
   logic [2*COEF_WIDTH-1:0] s1_dat;
   logic                    s1_vld;

   r4u1_twiddle_lut #(
      .COEF_WIDTH (COEF_WIDTH),
      .COEF_FRAC  (COEF_FRAC)
   ) u_lut (
      .addr (rom_addr),
      .coef (lut_dat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_dat <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= rd_en;
         if (rd_en) s1_dat <= lut_dat;
      end
   end

`ifdef R4U1_ROM_OUT_REG_EN
   logic [2*COEF_WIDTH-1:0] s2_dat;
   logic                    s2_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_dat <= '0;
         s2_vld <= 1'b0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) s2_dat <= s1_dat;
      end
   end

   assign rom_data  = s2_dat;
   assign rom_valid = s2_vld;
`else
   assign rom_data  = s1_dat;
   assign rom_valid = s1_vld;
`endif

endmodule

// File: tb/tb_r4u1_twiddle_rom.sv
// Directed bench for r4u1_twiddle_rom at COEF_WIDTH 16 and 12, both latency builds.
module tb_r4u1_twiddle_rom;

`ifdef R4U1_ROM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   // Hand-computed tables: Q1.14 and Q1.10 (value / 16, rounded half away from zero)
   localparam int T16_RE [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
   localparam int T16_IM [8] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};
   localparam int T12_RE [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
   localparam int T12_IM [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};

   logic        clk;
   logic        rst_n;
   logic        rd_en;
   logic [2:0]  rom_addr;
   logic [31:0] rom_data;
   logic        rom_valid;
   logic [23:0] rom_data12;
   logic        rom_valid12;

   int n_vec;
   int n_err;

   // reference pipeline state
   logic        m1_vld, m2_vld;
   logic [31:0] m1_d16, m2_d16;
   logic [23:0] m1_d12, m2_d12;

   r4u1_twiddle_rom #(.COEF_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rom_valid (rom_valid)
   );

   r4u1_twiddle_rom #(.COEF_WIDTH(12)) dut12 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data12),
      .rom_valid (rom_valid12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp16(input logic [2:0] k);
      int re;
      int im;
      re = T16_RE[k];
      im = T16_IM[k];
      return {re[15:0], im[15:0]};
   endfunction

   function automatic logic [23:0] exp12(input logic [2:0] k);
      int re;
      int im;
      re = T12_RE[k];
      im = T12_IM[k];
      return {re[11:0], im[11:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m1_vld = 1'b0; m2_vld = 1'b0;
      m1_d16 = '0;   m2_d16 = '0;
      m1_d12 = '0;   m2_d12 = '0;
   endtask

   task automatic check_outputs(input string tag);
      if (LAT == 1) begin
         check({tag, " data16"}, {32'd0, rom_data},   {32'd0, m1_d16});
         check({tag, " valid16"}, {63'd0, rom_valid}, {63'd0, m1_vld});
         check({tag, " data12"}, {40'd0, rom_data12}, {40'd0, m1_d12});
         check({tag, " valid12"}, {63'd0, rom_valid12}, {63'd0, m1_vld});
      end else begin
         check({tag, " data16"}, {32'd0, rom_data},   {32'd0, m2_d16});
         check({tag, " valid16"}, {63'd0, rom_valid}, {63'd0, m2_vld});
         check({tag, " data12"}, {40'd0, rom_data12}, {40'd0, m2_d12});
         check({tag, " valid12"}, {63'd0, rom_valid12}, {63'd0, m2_vld});
      end
   endtask

   // Apply inputs, take one rising edge, advance the reference, compare 1 ns later.
   task automatic step(input string tag, input logic en, input logic [2:0] a);
      rd_en    = en;
      rom_addr = a;
      @(posedge clk);
      #1;
      if (m1_vld) begin
         m2_d16 = m1_d16;
         m2_d12 = m1_d12;
      end
      m2_vld = m1_vld;
      m1_vld = en;
      if (en) begin
         m1_d16 = exp16(a);
         m1_d12 = exp12(a);
      end
      check_outputs(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " data16"}, {32'd0, rom_data},     64'd0);
      check({tag, " valid16"}, {63'd0, rom_valid},   64'd0);
      check({tag, " data12"}, {40'd0, rom_data12},   64'd0);
      check({tag, " valid12"}, {63'd0, rom_valid12}, 64'd0);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      rd_en    = 1'b1;
      rom_addr = 3'd3;
      model_clear();

      // reset held, inputs toggling
      #1;
      check_zero("reset_t0");
      for (int i = 0; i < 4; i++) begin
         rd_en    = 1'($urandom_range(0, 1));
         rom_addr = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         check_zero("reset_hold");
      end
      #2;
      rst_n = 1'b1;

      // sweep k = 0..7 back to back, then two trailing steps to flush latency
      for (int k = 0; k < 8; k++) step("sweep", 1'b1, 3'(k));
      step("sweep_tail", 1'b1, 3'd4);
      step("sweep_tail", 1'b0, 3'd0);
      step("sweep_tail", 1'b0, 3'd0);

      // gap: read k2 then idle with the address moving
      step("gap_rd", 1'b1, 3'd2);
      step("gap0", 1'b0, 3'd5);
      step("gap1", 1'b0, 3'd7);
      step("gap2", 1'b0, 3'd1);
      check("gap_k2_value16", {32'd0, rom_data}, {32'd0, 16'sd11585, -16'sd11585});
      check("gap_k2_value12", {40'd0, rom_data12}, {40'd0, 12'sd724, -12'sd724});

      // spot literals against the k1 / k4 encodings
      step("lit_k1", 1'b1, 3'd1);
      step("lit_k4", 1'b1, 3'd4);
      step("lit_idle", 1'b0, 3'd0);
      if (LAT == 1) check("lit_k4_hex", {32'd0, rom_data}, {32'd0, 32'h0000_C000});
      else          check("lit_k4_hex", {32'd0, rom_data}, {32'd0, 32'h0000_C000});
      step("lit_idle2", 1'b0, 3'd0);
      check("lit_k4_hold", {32'd0, rom_data}, {32'd0, 32'h0000_C000});

      // asynchronous reset mid-stream: outputs clear before the next edge
      step("pre_rst", 1'b1, 3'd7);
      step("pre_rst", 1'b1, 3'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      model_clear();
      @(posedge clk);
      #1;
      check_zero("async_rst_edge");
      #3;
      rst_n = 1'b1;

      // first read after release
      step("post_rst", 1'b1, 3'd1);
      step("post_rst", 1'b1, 3'd6);
      step("post_rst", 1'b0, 3'd3);

      // random traffic
      for (int i = 0; i < 1000; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
